// File: rtl/blink_game_ctrl.sv
// -----------------------------------------------------------------------------
// blink_game_ctrl
//   Round sequencer for the Blink game. Each round lights one pseudo-randomly
//   chosen LED, opens a timed response window, classifies the player's button
//   response as hit or miss, pulses the loss detector with that verdict, then
//   either scores the round or ends the game based on the detector's lose flag.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   start      start/restart request, honoured only in IDLE or OVER
//   btn        player buttons (debounced, synchronised), one per LED
//   lose_in    lose flag from the loss detector (valid one cycle after check_en)
//   hit_out    verdict to loss detector D input (1 = hit); holds between checks
//   check_en   one-cycle enable pulse to the loss detector
//   led        LED drive: one-hot target while waiting, all on when game over
//   score      hits this game, saturating
//   window     current response window in ticks
//   game_over  high while the game is over
// -----------------------------------------------------------------------------
module blink_game_ctrl #(
    parameter int N_LEDS     = 4,
    parameter int TICK_DIV   = 1000000,
    parameter int WIN_INIT   = 16,
    parameter int WIN_MIN    = 4,
    parameter int LEVEL_STEP = 4,
    parameter int GAP_TICKS  = 2,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_LEDS-1:0]  btn,
    input  logic               lose_in,
    output logic               hit_out,
    output logic               check_en,
    output logic [N_LEDS-1:0]  led,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         window,
    output logic               game_over
);

    localparam int SEL_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HCNT_W = $clog2(LEVEL_STEP + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]         WIN_INIT_V = 8'(WIN_INIT);
    localparam logic [7:0]         WIN_MIN_V  = 8'(WIN_MIN);
    localparam logic [7:0]         GAP_V      = 8'(GAP_TICKS);
    localparam logic [HCNT_W-1:0]  HCNT_LAST  = HCNT_W'(LEVEL_STEP - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_CHECK,
        S_RESULT,
        S_GAP,
        S_OVER
    } state_t;

    state_t              state_q,     state_d;
    logic [15:0]         lfsr_q,      lfsr_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [7:0]          timer_q,     timer_d;
    logic [HCNT_W-1:0]   hcnt_q,      hcnt_d;
    logic [N_LEDS-1:0]   btn_q,       btn_d;
    logic [N_LEDS-1:0]   led_q,       led_d;
    logic [SCORE_W-1:0]  score_q,     score_d;
    logic [7:0]          window_q,    window_d;
    logic                hit_out_q,   hit_out_d;
    logic                check_en_q,  check_en_d;
    logic                game_over_q, game_over_d;

    logic                tick;
    logic [N_LEDS-1:0]   btn_rise;
    logic [N_LEDS-1:0]   one_hot;

    assign tick     = (cnt_q == CNT_LAST);
    // Only fresh presses count; a button held across WAIT entry has btn_q set.
    assign btn_rise = btn & ~btn_q;
    assign one_hot  = N_LEDS'(1) << lfsr_q[SEL_W-1:0];

    always_comb begin
        state_d     = state_q;
        // Fibonacci LFSR, taps 16,14,13,11, free running in every state
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        timer_d     = timer_q;
        hcnt_d      = hcnt_q;
        btn_d       = btn;
        led_d       = led_q;
        score_d     = score_q;
        window_d    = window_q;
        hit_out_d   = hit_out_q;
        check_en_d  = 1'b0;
        game_over_d = game_over_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_ARM;
                    score_d     = '0;
                    window_d    = WIN_INIT_V;
                    hcnt_d      = '0;
                    game_over_d = 1'b0;
                    led_d       = '0;
                    // Counter reads zero during ARM so the window is exact.
                    cnt_d       = '0;
                end
            end
            S_ARM: begin
                led_d   = one_hot;
                timer_d = window_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A press beats a timeout landing in the same cycle.
                if (btn_rise != '0) begin
                    hit_out_d  = (btn_rise == led_q);
                    check_en_d = 1'b1;
                    led_d      = '0;
                    state_d    = S_CHECK;
                end else if (tick && (timer_q <= 8'd1)) begin
                    hit_out_d  = 1'b0;
                    check_en_d = 1'b1;
                    led_d      = '0;
                    state_d    = S_CHECK;
                end else if (tick) begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_CHECK: begin
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (lose_in) begin
                    game_over_d = 1'b1;
                    led_d       = '1;
                    state_d     = S_OVER;
                end else begin
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                    if (hcnt_q >= HCNT_LAST) begin
                        hcnt_d = '0;
                        if (window_q > WIN_MIN_V) begin
                            window_d = window_q - 8'd1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    // The dark gap is timed from a freshly cleared counter.
                    cnt_d   = '0;
                    timer_d = GAP_V;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (timer_q <= 8'd1) begin
                        cnt_d   = '0;
                        state_d = S_ARM;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            default: begin
                led_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 16'hACE1;
            cnt_q       <= '0;
            timer_q     <= '0;
            hcnt_q      <= '0;
            btn_q       <= '0;
            led_q       <= '0;
            score_q     <= '0;
            window_q    <= WIN_INIT_V;
            hit_out_q   <= 1'b0;
            check_en_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            hcnt_q      <= hcnt_d;
            btn_q       <= btn_d;
            led_q       <= led_d;
            score_q     <= score_d;
            window_q    <= window_d;
            hit_out_q   <= hit_out_d;
            check_en_q  <= check_en_d;
            game_over_q <= game_over_d;
        end
    end

    assign hit_out   = hit_out_q;
    assign check_en  = check_en_q;
    assign led       = led_q;
    assign score     = score_q;
    assign window    = window_q;
    assign game_over = game_over_q;

endmodule
